// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

  // A divisor of zero turns a channel off.
  localparam int DIV_OFF = 0;

  // Number of cycles clk_out stays high in a period of d cycles.
  function automatic logic [31:0] half_period(input logic [31:0] d);
    return d >> 1;
  endfunction

  // Width of a channel index; at least one bit so a single channel still has a port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, current/pending divisor and registered outputs.
// Latency: outputs are flops fed from a decode of the next counter/divisor state.
// Backpressure: a write is only presented when no divisor is already pending.
// Ports: hclkin/resetn clock and async reset; calib restarts the channel;
//        wr/wr_div accepted divisor write; clk_en/clk_out/pending channel outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic             hclkin,
  input  logic             resetn,
  input  logic             calib,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_en,
  output logic             clk_out,
  output logic             pending
);

  localparam logic [CNT_W-1:0] OFF   = CNT_W'(DIV_OFF);
  localparam logic [CNT_W-1:0] D_RST = CNT_W'(DIV_INIT);
  // Pre-start parks the counter at D-1 so the first edge after release wraps to 0.
  localparam logic [CNT_W-1:0] C_RST = (DIV_INIT == DIV_OFF) ? '0 : CNT_W'(DIV_INIT - 1);

  logic [CNT_W-1:0] d, cnt, p;
  logic             pend;
  logic [CNT_W-1:0] d_n, cnt_n, p_n;
  logic             pend_n;
  logic             en_n, out_n;

  always_comb begin
    d_n    = d;
    cnt_n  = cnt;
    p_n    = p;
    pend_n = pend;
    if (calib) begin
      // Restart: take any pending divisor now and park in pre-start.
      if (pend) d_n = p;
      pend_n = 1'b0;
      cnt_n  = (d_n == OFF) ? '0 : d_n - 1'b1;
    end else if (d == OFF) begin
      // An idle channel has no period to finish, so a write starts it at once.
      cnt_n = '0;
      if (wr) d_n = wr_div;
    end else begin
      if (cnt == d - 1'b1) begin
        // Period boundary. pend is the registered flag, so a write accepted on
        // this same edge is not consumed here.
        cnt_n = '0;
        if (pend) begin
          d_n    = p;
          pend_n = 1'b0;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
      if (wr) begin
        p_n    = wr_div;
        pend_n = 1'b1;
      end
    end
  end

  assign en_n  = !calib && (d_n != OFF) && (cnt_n == '0);
  assign out_n = !calib && (d_n != OFF) && (cnt_n < CNT_W'(half_period(32'(d_n))));

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      d       <= D_RST;
      cnt     <= C_RST;
      p       <= D_RST;
      pend    <= 1'b0;
      clk_en  <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      d       <= d_n;
      cnt     <= cnt_n;
      p       <= p_n;
      pend    <= pend_n;
      clk_en  <= en_n;
      clk_out <= out_n;
    end
  end

  assign pending = pend;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable divider with run-time divisor writes and calib restart.
// Latency: first clk_en one cycle after reset release or calib fall.
// Backpressure: cfg_ready drops while calib is high or the target channel has a write pending.
// Ports: hclkin/resetn clock and async reset; calib synchronous restart;
//        cfg_valid/cfg_ready/cfg_ch/cfg_div divisor write; clk_en/clk_out/pending per channel.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic                     hclkin,
  input  logic                     resetn,
  input  logic                     calib,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_idx_w(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]         cfg_div,
  output logic [NCH-1:0]           clk_en,
  output logic [NCH-1:0]           clk_out,
  output logic [NCH-1:0]           pending
);

  localparam int CH_W = ch_idx_w(NCH);

  logic sel_pend;
  logic accept;

  // Out-of-range channel numbers select nothing: accepted and dropped.
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) sel_pend = pending[i];
    end
  end

  assign cfg_ready = resetn && !calib && !sel_pend;
  assign accept    = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .hclkin  (hclkin),
      .resetn  (resetn),
      .calib   (calib),
      .wr      (accept && (cfg_ch == CH_W'(g))),
      .wr_div  (cfg_div),
      .clk_en  (clk_en[g]),
      .clk_out (clk_out[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen (NCH=2, CNT_W=8, DIV_INIT=4).
// Stimulus pushes expected per-cycle values; a negedge monitor pops and compares.
// Each period is described by a hand-scheduled divisor and phase per channel.
module tb_clk_div_gen;

    localparam int NCH = 2;

    typedef enum int {S_EN, S_OUT, S_PEND, S_RDY} sig_e;
    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [0:0] ch;
        logic       val;
        string      name;
    } exp_t;

    logic       hclkin;
    logic       resetn;
    logic       calib;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [1:0] clk_en;
    logic [1:0] clk_out;
    logic [1:0] pending;

    clk_div_gen #(.NCH(2), .CNT_W(8), .DIV_INIT(4)) dut (
        .hclkin    (hclkin),
        .resetn    (resetn),
        .calib     (calib),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_en    (clk_en),
        .clk_out   (clk_out),
        .pending   (pending)
    );

    initial begin
        hclkin = 1'b0;
        forever #5 hclkin = ~hclkin;
    end

    int   cyc = 0;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    // Expected divisor and phase (position within the period) per channel.
    int   dv[NCH];
    int   ph[NCH];

    always @(posedge hclkin) cyc <= cyc + 1;

    function automatic logic sample(input sig_e s, input logic [0:0] c);
        case (s)
            S_EN:    return clk_en[c];
            S_OUT:   return clk_out[c];
            S_PEND:  return pending[c];
            default: return cfg_ready;
        endcase
    endfunction

    // Monitor: every entry due in this cycle is compared; an overdue one is a failure.
    always @(negedge hclkin) begin
        exp_t e;
        logic act;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.sig, e.ch);
            n_tests++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s ch=%0d cyc=%0d due=%0d got=%b want=%b",
                         e.name, e.ch, cyc, e.cyc, act, e.val);
            end
        end
    end

    // Watchdog: the sequence must complete within a bounded number of cycles.
    initial begin
        repeat (2000) @(posedge hclkin);
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: sequence did not finish by cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic chk(input string nm, input sig_e s, input logic [0:0] c, input logic v);
        sb.push_back('{cyc, s, c, v, nm});
    endtask

    // Immediate comparison of a condition sampled right now.
    task automatic now_chk(input string nm, input logic ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cyc=%0d clk_en=%b clk_out=%b pending=%b cfg_ready=%b",
                     nm, cyc, clk_en, clk_out, pending, cfg_ready);
        end
    endtask

    // Wait for the next edge; hold=1 means outputs are forced (reset/calib pre-start).
    task automatic tick_adv(input bit hold);
        @(posedge hclkin);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (hold) ph[c] = (dv[c] > 0) ? dv[c] - 1 : 0;
            else if (dv[c] > 0) ph[c] = (ph[c] + 1) % dv[c];
        end
    endtask

    task automatic push_outs(input bit z);
        for (int c = 0; c < NCH; c++) begin
            logic e, o;
            e = !z && dv[c] > 0 && ph[c] == 0;
            o = !z && dv[c] > 0 && ph[c] < dv[c] / 2;
            chk("clk_en", S_EN, 1'(c), e);
            chk("clk_out", S_OUT, 1'(c), o);
        end
    endtask

    task automatic step();
        tick_adv(1'b0);
        push_outs(1'b0);
    endtask

    task automatic held();
        tick_adv(1'b1);
        push_outs(1'b1);
    endtask

    initial begin
        resetn = 1'b0; calib = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = 8'd0;
        dv[0] = 4; dv[1] = 4; ph[0] = 3; ph[1] = 3;

        // Reset state, then release: first clk_en one cycle later, pattern 1100.
        repeat (2) begin
            held();
            chk("rst_pend0", S_PEND, 1'b0, 1'b0);
            chk("rst_rdy", S_RDY, 1'b0, 1'b0);
        end
        now_chk("rst_state", clk_en == 2'b00 && clk_out == 2'b00 &&
                             pending == 2'b00 && cfg_ready == 1'b0);
        held();
        resetn = 1'b1;
        chk("rel_rdy", S_RDY, 1'b0, 1'b1);
        repeat (10) step();

        // Ch0 D=4 -> 5 written at cnt=1; applied 3 cycles later at the wrap.
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd5;
        chk("wr5_rdy", S_RDY, 1'b0, 1'b1);
        step(); cfg_valid = 1'b0;
        chk("wr5_pend", S_PEND, 1'b0, 1'b1);
        chk("wr5_rdy_busy", S_RDY, 1'b0, 1'b0);
        step();
        chk("wr5_pend", S_PEND, 1'b0, 1'b1);
        chk("wr5_rdy_busy", S_RDY, 1'b0, 1'b0);
        tick_adv(1'b0); dv[0] = 5; ph[0] = 0; push_outs(1'b0);
        chk("wr5_pend_clr", S_PEND, 1'b0, 1'b0);
        chk("wr5_rdy_back", S_RDY, 1'b0, 1'b1);
        repeat (10) step();

        // Ch1 off: current period finishes, then silent.
        for (int i = 0; i < 16 && ph[1] != 1; i++) step();
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd0;
        chk("off_rdy", S_RDY, 1'b0, 1'b1);
        step(); cfg_valid = 1'b0;
        chk("off_pend", S_PEND, 1'b1, 1'b1);
        chk("off_rdy_busy", S_RDY, 1'b0, 1'b0);
        step();
        chk("off_pend", S_PEND, 1'b1, 1'b1);
        tick_adv(1'b0); dv[1] = 0; ph[1] = 0; push_outs(1'b0);
        chk("off_pend_clr", S_PEND, 1'b1, 1'b0);
        chk("off_rdy_back", S_RDY, 1'b0, 1'b1);
        repeat (6) step();

        // Ch1 restart from off with D=3: runs the cycle after accept.
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd3;
        chk("on3_rdy", S_RDY, 1'b0, 1'b1);
        tick_adv(1'b0); dv[1] = 3; ph[1] = 0; push_outs(1'b0);
        cfg_valid = 1'b0;
        chk("on3_pend", S_PEND, 1'b1, 1'b0);
        repeat (7) step();

        // Back-to-back writes to both channels, then calib applies them at once.
        for (int i = 0; i < 16 && ph[0] != 0; i++) step();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd6;
        chk("b2b_rdy0", S_RDY, 1'b0, 1'b1);
        step(); cfg_ch = 1'b1; cfg_div = 8'd4;
        chk("b2b_rdy1", S_RDY, 1'b0, 1'b1);
        step(); cfg_valid = 1'b0; calib = 1'b1;
        chk("b2b_pend0", S_PEND, 1'b0, 1'b1);
        chk("b2b_pend1", S_PEND, 1'b1, 1'b1);
        chk("cal_rdy", S_RDY, 1'b0, 1'b0);
        dv[0] = 6; dv[1] = 4;
        held();
        chk("cal_pend0", S_PEND, 1'b0, 1'b0);
        chk("cal_pend1", S_PEND, 1'b1, 1'b0);
        held(); calib = 1'b0;
        chk("cal_rdy_back", S_RDY, 1'b0, 1'b1);
        repeat (13) step();

        // Out of phase (ch0 at 5, ch1 at 1): calib realigns; a write during calib is refused.
        repeat (5) step();
        calib = 1'b1; cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd2;
        chk("cal2_rdy", S_RDY, 1'b0, 1'b0);
        held();
        chk("cal2_rdy", S_RDY, 1'b0, 1'b0);
        held(); calib = 1'b0; cfg_valid = 1'b0;
        chk("cal2_pend1", S_PEND, 1'b1, 1'b0);
        repeat (14) step();

        // Write in the wrap cycle: the coincident wrap keeps D=6; next wrap takes D=2.
        for (int i = 0; i < 16 && ph[0] != 5; i++) step();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd2;
        chk("wrap_rdy", S_RDY, 1'b0, 1'b1);
        step(); cfg_valid = 1'b0;
        chk("wrap_pend", S_PEND, 1'b0, 1'b1);
        repeat (5) begin
            step();
            chk("wrap_pend", S_PEND, 1'b0, 1'b1);
        end
        tick_adv(1'b0); dv[0] = 2; ph[0] = 0; push_outs(1'b0);
        chk("wrap_pend_clr", S_PEND, 1'b0, 1'b0);
        repeat (4) step();

        // Reset mid-period with a write pending: outputs drop at once, write is lost.
        for (int i = 0; i < 16 && ph[1] != 3; i++) step();
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd7;
        chk("mrst_rdy", S_RDY, 1'b0, 1'b1);
        step(); cfg_valid = 1'b0;
        chk("mrst_pend", S_PEND, 1'b1, 1'b1);
        tick_adv(1'b0);
        resetn = 1'b0;
        #1;
        now_chk("mrst_async", clk_en == 2'b00 && clk_out == 2'b00 && pending == 2'b00);
        push_outs(1'b1);
        chk("mrst_pend_clr", S_PEND, 1'b1, 1'b0);
        chk("mrst_rdy", S_RDY, 1'b0, 1'b0);
        dv[0] = 4; dv[1] = 4;
        held();
        held();
        resetn = 1'b1;
        chk("mrst_rel_rdy", S_RDY, 1'b0, 1'b1);
        step();
        chk("mrst_pend_lost", S_PEND, 1'b1, 1'b0);
        repeat (9) step();

        repeat (2) @(posedge hclkin);
        #1;
        now_chk("sb_drained", sb.size() == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
